reg_file_unit: RTL and testbench



---
 rtl/reg_file_unit.sv | 75 +++++++
 tb/tb_reg_file_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_unit.sv
// Purpose : 8 x 16-bit operand register file for the ALU with write-through bypass, r0 hardwired to 0, and the architectural zero flag.
// Latency : reads are combinational (0 cycles); writes and the flag capture take effect one rising edge later.
// Backpressure: none. The block always accepts writes and reads; there is no stall path.
// Ports   : clk/rst_n (sync, active-low); RF_AddrA/RF_AddrB -> RF_OutA/RF_OutB read ports;
//           RF_WrEn/RF_WrAddr/RF_WrData write port; Flag_En/ALU_zero_in -> Zero_flag.
module reg_file_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RF_AddrA,
    input  logic [ADDR_W-1:0] RF_AddrB,
    output logic [DATA_W-1:0] RF_OutA,
    output logic [DATA_W-1:0] RF_OutB,
    input  logic              RF_WrEn,
    input  logic [ADDR_W-1:0] RF_WrAddr,
    input  logic [DATA_W-1:0] RF_WrData,
    input  logic              Flag_En,
    input  logic              ALU_zero_in,
    output logic              Zero_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    // r0 has no storage; only r1..r(DEPTH-1) are flops.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    logic              wr_live;
    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    // A write to index 0 is dropped and never bypassed.
    assign wr_live = RF_WrEn && (RF_WrAddr != '0);

    // Bypass is suppressed during reset so RF_WrData never leaks out while the write is being discarded.
    assign byp_a = rst_n && wr_live && (RF_WrAddr == RF_AddrA);
    assign byp_b = rst_n && wr_live && (RF_WrAddr == RF_AddrB);

    // Storage update. The write decode is qualified by RF_WrEn first so an
    // unknown write address with the enable low can never select a register.
    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (RF_WrEn && (RF_WrAddr == ADDR_W'(i))) begin
                regs[i] <= RF_WrData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Zero_flag <= 1'b0;
        end else if (Flag_En) begin
            Zero_flag <= ALU_zero_in;
        end
    end

    // Read muxes: index 0 falls through to the zero default.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (RF_AddrA == ADDR_W'(i)) stored_a = regs[i];
            if (RF_AddrB == ADDR_W'(i)) stored_b = regs[i];
        end
    end

    assign RF_OutA = byp_a ? RF_WrData : stored_a;
    assign RF_OutB = byp_b ? RF_WrData : stored_b;

endmodule

// File: tb/tb_reg_file_unit.sv
module tb_reg_file_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  RF_AddrA;
    logic [2:0]  RF_AddrB;
    logic [15:0] RF_OutA;
    logic [15:0] RF_OutB;
    logic        RF_WrEn;
    logic [2:0]  RF_WrAddr;
    logic [15:0] RF_WrData;
    logic        Flag_En;
    logic        ALU_zero_in;
    logic        Zero_flag;

    reg_file_unit #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RF_AddrA   (RF_AddrA),
        .RF_AddrB   (RF_AddrB),
        .RF_OutA    (RF_OutA),
        .RF_OutB    (RF_OutB),
        .RF_WrEn    (RF_WrEn),
        .RF_WrAddr  (RF_WrAddr),
        .RF_WrData  (RF_WrData),
        .Flag_En    (Flag_En),
        .ALU_zero_in(ALU_zero_in),
        .Zero_flag  (Zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        z;
    } exp_t;

    exp_t q[$];
    logic chk_vld;
    int   errors;
    int   checks;

    // Monitor: mid-cycle, whenever the stimulus marks the cycle as observable,
    // pop the next expectation and compare against the live outputs.
    always @(negedge clk) begin
        if (chk_vld) begin
            checks = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL %s: no expectation queued, got A=%h B=%h Z=%b", "underflow", RF_OutA, RF_OutB, Zero_flag);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (RF_OutA !== e.a || RF_OutB !== e.b || Zero_flag !== e.z) begin
                    errors = errors + 1;
                    $display("FAIL %s: got A=%h B=%h Z=%b, expected A=%h B=%h Z=%b",
                             e.name, RF_OutA, RF_OutB, Zero_flag, e.a, e.b, e.z);
                end
            end
        end
    end

    // One clock cycle of stimulus with the expected mid-cycle outputs.
    task automatic cyc(input string name, input logic rst, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] aa, input logic [2:0] ab,
                       input logic fe, input logic zi,
                       input logic [15:0] ea, input logic [15:0] eb, input logic ez);
        exp_t e;
        rst_n       = rst;
        RF_WrEn     = we;
        RF_WrAddr   = wa;
        RF_WrData   = wd;
        RF_AddrA    = aa;
        RF_AddrB    = ab;
        Flag_En     = fe;
        ALU_zero_in = zi;
        e.name = name;
        e.a    = ea;
        e.b    = eb;
        e.z    = ez;
        q.push_back(e);
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        errors      = 0;
        checks      = 0;
        chk_vld     = 1'b0;
        rst_n       = 1'b0;
        RF_WrEn     = 1'b0;
        RF_WrAddr   = 3'd0;
        RF_WrData   = 16'h0;
        RF_AddrA    = 3'd0;
        RF_AddrB    = 3'd0;
        Flag_En     = 1'b0;
        ALU_zero_in = 1'b0;
        @(posedge clk);
        #1;

        // Preload r1..r7 = FFFF. Port A sees the bypass, port B the previous (stored) register.
        for (int i = 1; i < 8; i++) begin
            logic [2:0] ia, ib;
            ia = 3'(i);
            ib = 3'(i - 1);
            cyc("preload", 1, 1, ia, 16'hFFFF, ia, ib, 0, 0,
                16'hFFFF, (i == 1) ? 16'h0000 : 16'hFFFF, 0);
        end
        cyc("preload_rd", 1, 0, 3'd0, 16'h0, 3'd7, 3'd4, 0, 0, 16'hFFFF, 16'hFFFF, 0);
        // Set the flag so reset has something to clear.
        cyc("flag_set", 1, 0, 3'd0, 16'h0, 3'd1, 3'd2, 1, 1, 16'hFFFF, 16'hFFFF, 0);
        // Reset dominance: write r2=5555 and flag capture both lost; no bypass during reset.
        cyc("rst_dom", 0, 1, 3'd2, 16'h5555, 3'd2, 3'd1, 1, 1, 16'hFFFF, 16'hFFFF, 1);
        for (int i = 0; i < 8; i++) begin
            cyc("post_rst", 1, 0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 0, 0, 16'h0000, 16'h0000, 0);
        end

        // Write / readback.
        cyc("wr_r3",    1, 1, 3'd3, 16'h1234, 3'd3, 3'd7, 0, 0, 16'h1234, 16'h0000, 0);
        cyc("wr_r7",    1, 1, 3'd7, 16'hBEEF, 3'd3, 3'd7, 0, 0, 16'h1234, 16'hBEEF, 0);
        cyc("rd_r3_r7", 1, 0, 3'd0, 16'h0,    3'd3, 3'd7, 0, 0, 16'h1234, 16'hBEEF, 0);

        // r0 protection.
        cyc("wr_r0",    1, 1, 3'd0, 16'hAAAA, 3'd0, 3'd3, 0, 0, 16'h0000, 16'h1234, 0);
        cyc("rd_r0",    1, 0, 3'd0, 16'h0,    3'd0, 3'd0, 0, 0, 16'h0000, 16'h0000, 0);

        // Bypass on both ports, then independent bypass.
        cyc("wr_r5_1",  1, 1, 3'd5, 16'h0001, 3'd5, 3'd5, 0, 0, 16'h0001, 16'h0001, 0);
        cyc("byp_r5",   1, 1, 3'd5, 16'h00F0, 3'd5, 3'd5, 0, 0, 16'h00F0, 16'h00F0, 0);
        cyc("rd_r5",    1, 0, 3'd0, 16'h0,    3'd5, 3'd5, 0, 0, 16'h00F0, 16'h00F0, 0);
        cyc("byp_a_only", 1, 1, 3'd6, 16'h0606, 3'd6, 3'd5, 0, 0, 16'h0606, 16'h00F0, 0);
        cyc("byp_b_only", 1, 1, 3'd4, 16'h0404, 3'd6, 3'd4, 0, 0, 16'h0606, 16'h0404, 0);

        // Write enable low with an unknown address must not disturb anything.
        cyc("we0_xaddr", 1, 0, 3'bxxx, 16'hDEAD, 3'd6, 3'd3, 0, 0, 16'h0606, 16'h1234, 0);
        cyc("we0_after", 1, 0, 3'd0,   16'h0,    3'd6, 3'd4, 0, 0, 16'h0606, 16'h0404, 0);

        // Zero flag: r1 - r2 = 4 - 4 = 0 -> zero=1; then r1 - r7 != 0 with Flag_En=0 -> holds.
        cyc("wr_r1_4",  1, 1, 3'd1, 16'h0004, 3'd1, 3'd2, 0, 0, 16'h0004, 16'h0000, 0);
        cyc("wr_r2_4",  1, 1, 3'd2, 16'h0004, 3'd1, 3'd2, 0, 0, 16'h0004, 16'h0004, 0);
        cyc("flag_cap", 1, 0, 3'd0, 16'h0,    3'd1, 3'd2, 1, 1, 16'h0004, 16'h0004, 0);
        cyc("flag_hold",1, 0, 3'd0, 16'h0,    3'd1, 3'd7, 0, 0, 16'h0004, 16'hBEEF, 1);
        // Write and flag capture in the same cycle are independent.
        cyc("flag_clr_wr", 1, 1, 3'd3, 16'h3333, 3'd3, 3'd7, 1, 0, 16'h3333, 16'hBEEF, 1);
        cyc("flag_clr", 1, 0, 3'd0, 16'h0,    3'd3, 3'd1, 0, 0, 16'h3333, 16'h0004, 0);

        // Reset between back-to-back writes: the reset-edge write is lost, the next one lands.
        cyc("mid_wr1",  1, 1, 3'd4, 16'h1111, 3'd4, 3'd1, 0, 0, 16'h1111, 16'h0004, 0);
        cyc("mid_rst",  0, 1, 3'd4, 16'h2222, 3'd4, 3'd1, 0, 0, 16'h1111, 16'h0004, 0);
        cyc("mid_wr3",  1, 1, 3'd4, 16'h3333, 3'd4, 3'd1, 0, 0, 16'h3333, 16'h0000, 0);
        cyc("mid_rd",   1, 0, 3'd0, 16'h0,    3'd4, 3'd3, 0, 0, 16'h3333, 16'h0000, 0);

        chk_vld = 1'b0;
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
